// File: rtl/mem_pkg.sv
// Shared types and defaults for the cache-to-memory arbiter.
package mem_pkg;

  localparam int unsigned MEM_WORD_SIZE   = 32;
  localparam int unsigned MEM_LATENCY_DEF = 5;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } mem_src_t;

  typedef struct packed {
    logic                     valid;
    mem_src_t                 src;
    logic [MEM_WORD_SIZE-1:0] addr;
  } mem_pipe_entry_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache request/response and main-memory port bundle for mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned LINE_SIZE = 128
);
  logic                 ic_req;
  logic [WORD_SIZE-1:0] ic_req_addr;
  logic                 ic_ready;
  logic                 ic_res;
  logic [WORD_SIZE-1:0] ic_res_addr;
  logic [LINE_SIZE-1:0] ic_res_data;

  logic                 dc_req;
  logic [WORD_SIZE-1:0] dc_req_addr;
  logic                 dc_ready;
  logic                 dc_res;
  logic [WORD_SIZE-1:0] dc_res_addr;
  logic [LINE_SIZE-1:0] dc_res_data;

  logic                 dc_write;
  logic [WORD_SIZE-1:0] dc_write_addr;
  logic [LINE_SIZE-1:0] dc_write_data;
  logic                 dc_write_ready;

  logic                 mem_valid;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [LINE_SIZE-1:0] mem_wdata;
  logic [LINE_SIZE-1:0] mem_rdata;

  logic                 overflow_err;

  modport slave (
    input  ic_req, ic_req_addr, dc_req, dc_req_addr,
           dc_write, dc_write_addr, dc_write_data, mem_rdata,
    output ic_ready, ic_res, ic_res_addr, ic_res_data,
           dc_ready, dc_res, dc_res_addr, dc_res_data, dc_write_ready,
           mem_valid, mem_we, mem_addr, mem_wdata, overflow_err
  );

  modport master (
    output ic_req, ic_req_addr, dc_req, dc_req_addr,
           dc_write, dc_write_addr, dc_write_data, mem_rdata,
    input  ic_ready, ic_res, ic_res_addr, ic_res_data,
           dc_ready, dc_res, dc_res_addr, dc_res_data, dc_write_ready,
           mem_valid, mem_we, mem_addr, mem_wdata, overflow_err
  );
endinterface

// File: rtl/mem_req_fifo.sv
// Small synchronous FIFO holding queued memory requests; caller guards push/pop.
module mem_req_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (pop) r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache refills, D-cache refills and D-cache evictions onto one
// fixed-latency memory port and routes read data back to the requester.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = MEM_WORD_SIZE,
  parameter int unsigned LINE_SIZE   = 128,
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int unsigned Q_DEPTH     = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned WQ_W = WORD_SIZE + LINE_SIZE;

  logic                 w_iq_push, w_iq_pop, w_iq_full, w_iq_empty;
  logic                 w_dq_push, w_dq_pop, w_dq_full, w_dq_empty;
  logic                 w_wq_push, w_wq_pop, w_wq_full, w_wq_empty;
  logic [WORD_SIZE-1:0] w_iq_addr, w_dq_addr;
  logic [WQ_W-1:0]      w_wq_head;

  logic                 w_iss_wr, w_iss_rd;
  mem_src_t             w_rd_src;
  logic [WORD_SIZE-1:0] w_rd_addr;
  logic                 r_last_rd;
  logic                 r_overflow_err;

  mem_pipe_entry_t      r_pipe [MEM_LATENCY];
  mem_pipe_entry_t      w_tail;
  logic                 w_ic_res, w_dc_res;

  assign w_iq_push = bus.ic_req   & ~w_iq_full;
  assign w_dq_push = bus.dc_req   & ~w_dq_full;
  assign w_wq_push = bus.dc_write & ~w_wq_full;

  mem_req_fifo #(.WIDTH(WORD_SIZE), .DEPTH(Q_DEPTH)) u_iq (
    .clk(clk), .rst(rst), .push(w_iq_push), .din(bus.ic_req_addr),
    .pop(w_iq_pop), .dout(w_iq_addr), .full(w_iq_full), .empty(w_iq_empty)
  );

  mem_req_fifo #(.WIDTH(WORD_SIZE), .DEPTH(Q_DEPTH)) u_dq (
    .clk(clk), .rst(rst), .push(w_dq_push), .din(bus.dc_req_addr),
    .pop(w_dq_pop), .dout(w_dq_addr), .full(w_dq_full), .empty(w_dq_empty)
  );

  mem_req_fifo #(.WIDTH(WQ_W), .DEPTH(Q_DEPTH)) u_wq (
    .clk(clk), .rst(rst), .push(w_wq_push),
    .din({bus.dc_write_addr, bus.dc_write_data}),
    .pop(w_wq_pop), .dout(w_wq_head), .full(w_wq_full), .empty(w_wq_empty)
  );

  // r_last_rd = 1 means the I-cache was served last, so the D-cache wins a tie.
  always_comb begin
    w_iss_wr = ~w_wq_empty;
    w_iss_rd = w_wq_empty & (~w_iq_empty | ~w_dq_empty);
    if (~w_iq_empty & ~w_dq_empty) w_rd_src = r_last_rd ? SRC_DC : SRC_IC;
    else if (~w_dq_empty)          w_rd_src = SRC_DC;
    else                           w_rd_src = SRC_IC;
    w_rd_addr = (w_rd_src == SRC_DC) ? w_dq_addr : w_iq_addr;
    w_wq_pop  = w_iss_wr;
    w_iq_pop  = w_iss_rd & (w_rd_src == SRC_IC);
    w_dq_pop  = w_iss_rd & (w_rd_src == SRC_DC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_rd      <= 1'b1;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_iss_rd) r_last_rd <= (w_rd_src == SRC_IC);
      if ((bus.ic_req & w_iq_full) | (bus.dc_req & w_dq_full) |
          (bus.dc_write & w_wq_full))
        r_overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{valid: w_iss_rd, src: w_rd_src,
                     addr: MEM_WORD_SIZE'(w_rd_addr)};
      for (int unsigned i = 1; i < MEM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tail   = r_pipe[MEM_LATENCY-1];
  assign w_ic_res = w_tail.valid & (w_tail.src == SRC_IC);
  assign w_dc_res = w_tail.valid & (w_tail.src == SRC_DC);

  assign bus.ic_ready       = ~w_iq_full;
  assign bus.dc_ready       = ~w_dq_full;
  assign bus.dc_write_ready = ~w_wq_full;
  assign bus.overflow_err   = r_overflow_err;

  assign bus.mem_valid = w_iss_wr | w_iss_rd;
  assign bus.mem_we    = w_iss_wr;
  assign bus.mem_addr  = w_iss_wr ? w_wq_head[WQ_W-1:LINE_SIZE] :
                         (w_iss_rd ? w_rd_addr : '0);
  assign bus.mem_wdata = w_iss_wr ? w_wq_head[LINE_SIZE-1:0] : '0;

  assign bus.ic_res      = w_ic_res;
  assign bus.ic_res_addr = w_ic_res ? WORD_SIZE'(w_tail.addr) : '0;
  assign bus.ic_res_data = w_ic_res ? bus.mem_rdata : '0;
  assign bus.dc_res      = w_dc_res;
  assign bus.dc_res_addr = w_dc_res ? WORD_SIZE'(w_tail.addr) : '0;
  assign bus.dc_res_data = w_dc_res ? bus.mem_rdata : '0;

endmodule
